bin2seg_ahb_writer: RTL and testbench
=====================================

Name: bin2seg_ahb_writer

Overview:
- AHB-Lite write-only master that feeds the 8-digit seven-segment display slave.
- Accepts a 32-bit value over a valid/ready handshake and converts it to 8 digits: sequential double-dabble for decimal, direct nibbles for hex.
- Packs each digit with its decimal-point flag into a byte, then issues two word writes to the display slave's digit registers (BASE_ADDR, BASE_ADDR+4).

Parameters:
- BASE_ADDR, 16'h0000, slave address of digit register 0 (digits 0-3); digits 4-7 are at BASE_ADDR+4.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset; asynchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  high only in IDLE
- in_value  in  32  value to display
- in_hex  in  1  1 = hex nibbles, 0 = decimal
- in_dp  in  8  per-digit decimal-point mask; bit i = digit i; digit 0 is least significant
- busy  out  1  high when not IDLE
- done  out  1  one-cycle pulse when the second data phase completes
- bus_err  out  1  valid with done; 1 if either data phase saw HRESP=1
- HADDR  out  16  AHB address
- HTRANS  out  2  2'b00 IDLE or 2'b10 NONSEQ only
- HSIZE  out  3  constant 3'b010
- HWRITE  out  1  constant 1
- HWDATA  out  32  write data
- HREADY  in  1  transfer done / bus ready
- HRESP  in  1  slave response

Behaviour:
- Reset values: state IDLE, HTRANS=2'b00, HADDR=BASE_ADDR, HWDATA=0, done=0, bus_err=0, busy=0, in_ready=1, all internal registers 0.
- Reset mid-operation aborts immediately to IDLE. No further bus activity until a new request is accepted.
- Accept: on an edge where in_valid & in_ready, latch in_value, in_hex and in_dp.
- Next state after accept:
  - in_hex=1: next state A0; digit i = in_value[4i+3:4i].
  - in_hex=0 and in_value > 99_999_999: overflow; next state A0; all digits = 4'hF.
  - otherwise: next state CONV.
- CONV: exactly 32 cycles. Each cycle, every BCD digit >= 5 gets +3, then {bcd[31:0], bin[31:0]} shifts left by 1. A 6-bit counter counts 0..31; after iteration 31 go to A0.
- Byte i = {3'b000, in_dp[i], digit_i}. Word0 = {byte3, byte2, byte1, byte0}; word1 = {byte7..byte4}.
- A0: HTRANS=NONSEQ, HADDR=BASE_ADDR. On HREADY go to D0A1; otherwise hold.
- D0A1:
  - Drives HWDATA=word0 (data phase 0) and, overlapped, HTRANS=NONSEQ, HADDR=BASE_ADDR+4 (address phase 1).
  - All outputs held while HREADY=0.
  - On HREADY: sample HRESP into the error flag, go to D1.
- D1: HTRANS=IDLE, HWDATA=word1, held while HREADY=0. On HREADY: OR in HRESP, go to IDLE, assert done=1 for one cycle, bus_err = error flag.
- All AHB outputs are registered. Error flag clears on accept.
- HREADY constantly 1: done is high in the cycle after the 35th edge following accept (decimal) or the 3rd edge (hex/overflow).
- in_valid while busy is ignored (in_ready=0). A new request may be accepted on the same edge done is visible, since the state is already IDLE.

Test Plan:
- Decimal 12345678, dp=0, HREADY=1 -> write 0x0000 data 0x05060708, write 0x0004 data 0x01020304; done 35 edges after accept; bus_err=0.
- Hex 0xDEADBEEF, dp=8'h81 -> word0=0x0B0E0E1F, word1=0x1D0E0A0D; done 3 edges after accept.
- Decimal 100000000 (overflow) -> both words 0x0F0F0F0F, no CONV cycles. Decimal 0 -> both words 0x00000000 after 35 edges.
- HREADY=0 for 3 cycles in D0A1 -> HADDR=0x0004, HTRANS=2'b10, HWDATA=word0 stable throughout; then completes normally. HRESP=1 in D1 -> done with bus_err=1.
- HRESETn low at CONV cycle 10 -> HTRANS=00, busy=0, in_ready=1 at once; no write issued. A following request for 42 completes normally with word0=0x00000402.
- Back-to-back: in_valid held high with two values -> second accepted the cycle done is high; four writes in order, no HTRANS glitch between requests.

Source files
------------

// File: rtl/bin2seg_ahb_writer.sv
// bin2seg_ahb_writer
//   AHB-Lite write-only master feeding an 8-digit seven-segment display slave.
//   A 32-bit value is accepted over valid/ready. It is turned into 8 digits:
//   double-dabble (32 cycles) for decimal, or the raw nibbles for hex.
//   Values above 99_999_999 in decimal mode show all digits as F.
//   Each digit is packed with its decimal-point flag into a byte. The bytes are
//   then written as two words: BASE_ADDR for digits 0-3 and BASE_ADDR+4 for
//   digits 4-7. The second address phase overlaps the first data phase.
//
// Ports
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   in_valid/in_ready    request handshake (in_ready high only in IDLE)
//   in_value, in_hex     value and mode (1 = hex nibbles, 0 = decimal)
//   in_dp                per-digit decimal-point mask, bit i = digit i
//   busy                 high whenever not IDLE
//   done, bus_err        one-cycle completion pulse; bus_err valid with done
//   HADDR..HWDATA        registered AHB-Lite master outputs
//   HREADY, HRESP        AHB-Lite slave response
module bin2seg_ahb_writer #(
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    input  logic        in_hex,
    input  logic [7:0]  in_dp,
    output logic        busy,
    output logic        done,
    output logic        bus_err,
    output logic [15:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam logic [1:0]  TR_IDLE   = 2'b00;
    localparam logic [1:0]  TR_NONSEQ = 2'b10;
    localparam logic [15:0] ADDR1     = BASE_ADDR + 16'd4;

    typedef enum logic [2:0] {S_IDLE, S_CONV, S_A0, S_D0A1, S_D1} state_t;

    state_t      state, state_nx;
    logic [31:0] bcd;      // 8 BCD/hex digits, digit 0 in [3:0]
    logic [31:0] bin;      // binary shift register for double-dabble
    logic [7:0]  dp;
    logic [5:0]  cnt;
    logic        err;
    logic        accept;
    logic [31:0] bcd_adj;
    logic [31:0] word0, word1;

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);
    assign accept   = in_valid & in_ready;
    assign HSIZE    = 3'b010;
    assign HWRITE   = 1'b1;

    // Add-3 correction applied before each shift of the double-dabble.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 8; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = 4'(bcd[4*i +: 4] + 4'd3);
            else
                bcd_adj[4*i +: 4] = bcd[4*i +: 4];
        end
    end

    // Byte i = {3'b000, dp[i], digit i}.
    always_comb begin
        word0 = '0;
        word1 = '0;
        for (int i = 0; i < 4; i++) begin
            word0[8*i +: 8] = {3'b000, dp[i],   bcd[4*i +: 4]};
            word1[8*i +: 8] = {3'b000, dp[i+4], bcd[4*(i+4) +: 4]};
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept)
                        state_nx = (in_hex || in_value > 32'd99_999_999) ? S_A0 : S_CONV;
            S_CONV: if (cnt == 6'd31) state_nx = S_A0;
            S_A0:   if (HREADY) state_nx = S_D0A1;
            S_D0A1: if (HREADY) state_nx = S_D1;
            S_D1:   if (HREADY) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Datapath: load on accept, shift during CONV.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            bcd <= '0;
            bin <= '0;
            dp  <= '0;
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (accept) begin
                dp  <= in_dp;
                cnt <= '0;
                err <= 1'b0;
                bin <= in_value;
                if (in_hex)                          bcd <= in_value;
                else if (in_value > 32'd99_999_999)  bcd <= 32'hFFFF_FFFF;
                else                                 bcd <= '0;
            end else if (state == S_CONV) begin
                bcd <= {bcd_adj[30:0], bin[31]};
                bin <= {bin[30:0], 1'b0};
                cnt <= cnt + 6'd1;
            end else if (state == S_D0A1 && HREADY) begin
                err <= HRESP;
            end
        end
    end

    // AHB outputs are registered from the next state, so they hold
    // automatically while HREADY is low.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HTRANS  <= TR_IDLE;
            HADDR   <= BASE_ADDR;
            HWDATA  <= '0;
            done    <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            HTRANS  <= (state_nx == S_A0 || state_nx == S_D0A1) ? TR_NONSEQ : TR_IDLE;
            if (state_nx == S_A0)   HADDR  <= BASE_ADDR;
            if (state_nx == S_D0A1) begin
                HADDR  <= ADDR1;
                HWDATA <= word0;
            end
            if (state_nx == S_D1)   HWDATA <= word1;
            done    <= (state == S_D1) && HREADY;
            bus_err <= (state == S_D1) && HREADY && (err | HRESP);
        end
    end

endmodule

// File: tb/tb_bin2seg_ahb_writer.sv
// Directed testbench for bin2seg_ahb_writer. Inputs change 1 ns after the
// rising edge; a negedge monitor records completed write addresses and data.
module tb_bin2seg_ahb_writer;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_value = '0;
    logic        in_hex = 1'b0;
    logic [7:0]  in_dp = '0;
    logic        busy, done, bus_err;
    logic [15:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;

    int checks = 0;
    int errors = 0;

    bin2seg_ahb_writer #(.BASE_ADDR(16'h0000)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
        .in_hex(in_hex), .in_dp(in_dp), .busy(busy), .done(done),
        .bus_err(bus_err), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    // Bus monitor
    logic [15:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic        dph;

    always @(negedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dph <= 1'b0;
        end else if (HREADY) begin
            if (dph) wd_q.push_back(HWDATA);
            if (HTRANS == 2'b10) wa_q.push_back(HADDR);
            dph <= (HTRANS == 2'b10);
        end
    end

    // Issue one request from IDLE and count edges after the accept edge
    // until done is seen.
    task automatic run_req(input logic [31:0] v, input logic h,
                           input logic [7:0] d, output int edges);
        in_value = v; in_hex = h; in_dp = d; in_valid = 1'b1;
        @(posedge HCLK); #1;
        in_valid = 1'b0;
        edges = 0;
        while (!done && edges < 200) begin
            @(posedge HCLK); #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (HTRANS !== 2'b00 || HADDR !== 16'h0000 || HWDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: HTRANS=%b HADDR=%h HWDATA=%h, want 00/0000/00000000", HTRANS, HADDR, HWDATA);
        end
        checks++;
        if (done !== 1'b0 || bus_err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctl: done=%b bus_err=%b busy=%b in_ready=%b, want 0/0/0/1", done, bus_err, busy, in_ready);
        end
        checks++;
        if (HSIZE !== 3'b010 || HWRITE !== 1'b1) begin
            errors++;
            $display("FAIL reset_const: HSIZE=%b HWRITE=%b, want 010/1", HSIZE, HWRITE);
        end
    endtask

    task automatic test_value(input string nm, input logic [31:0] v, input logic h,
                              input logic [7:0] d, input int exp_edges,
                              input logic [31:0] w0, input logic [31:0] w1);
        int e;
        wa_q.delete(); wd_q.delete();
        run_req(v, h, d, e);
        checks++;
        if (e !== exp_edges) begin
            errors++;
            $display("FAIL %s_latency: done after %0d edges, want %0d", nm, e, exp_edges);
        end
        checks++;
        if (bus_err !== 1'b0) begin
            errors++;
            $display("FAIL %s_buserr: got %b want 0", nm, bus_err);
        end
        checks++;
        if (wa_q.size() != 2 || wd_q.size() != 2) begin
            errors++;
            $display("FAIL %s_count: %0d addr %0d data, want 2/2", nm, wa_q.size(), wd_q.size());
        end else if (wa_q[0] !== 16'h0000 || wa_q[1] !== 16'h0004 || wd_q[0] !== w0 || wd_q[1] !== w1) begin
            errors++;
            $display("FAIL %s_writes: %h:%h %h:%h, want 0000:%h 0004:%h",
                     nm, wa_q[0], wd_q[0], wa_q[1], wd_q[1], w0, w1);
        end
    endtask

    task automatic test_stall_err();
        wa_q.delete(); wd_q.delete();
        in_value = 32'h1234_5678; in_hex = 1'b1; in_dp = 8'h00; in_valid = 1'b1;
        @(posedge HCLK); #1;            // accepted, A0
        in_valid = 1'b0;
        @(posedge HCLK); #1;            // D0A1
        HREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge HCLK); #1;
            checks++;
            if (HADDR !== 16'h0004 || HTRANS !== 2'b10 || HWDATA !== 32'h0506_0708) begin
                errors++;
                $display("FAIL stall_hold%0d: HADDR=%h HTRANS=%b HWDATA=%h, want 0004/10/05060708", k, HADDR, HTRANS, HWDATA);
            end
        end
        HREADY = 1'b1;
        @(posedge HCLK); #1;            // D1
        checks++;
        if (HTRANS !== 2'b00 || HWDATA !== 32'h0102_0304 || done !== 1'b0) begin
            errors++;
            $display("FAIL stall_d1: HTRANS=%b HWDATA=%h done=%b, want 00/01020304/0", HTRANS, HWDATA, done);
        end
        HRESP = 1'b1;
        @(posedge HCLK); #1;
        HRESP = 1'b0;
        checks++;
        if (done !== 1'b1 || bus_err !== 1'b1) begin
            errors++;
            $display("FAIL resp_err: done=%b bus_err=%b, want 1/1", done, bus_err);
        end
        checks++;
        if (wd_q.size() != 2 || wa_q.size() != 2) begin
            errors++;
            $display("FAIL stall_count: %0d addr %0d data, want 2/2", wa_q.size(), wd_q.size());
        end else if (wd_q[0] !== 32'h0506_0708 || wd_q[1] !== 32'h0102_0304) begin
            errors++;
            $display("FAIL stall_writes: %h %h, want 05060708 01020304", wd_q[0], wd_q[1]);
        end
        @(posedge HCLK); #1;
    endtask

    task automatic test_reset_midop();
        wa_q.delete(); wd_q.delete();
        in_value = 32'd12345678; in_hex = 1'b0; in_dp = 8'h00; in_valid = 1'b1;
        @(posedge HCLK); #1;
        in_valid = 1'b0;
        repeat (10) begin @(posedge HCLK); #1; end
        HRESETn = 1'b0;
        #1;
        checks++;
        if (HTRANS !== 2'b00 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midop_reset: HTRANS=%b busy=%b in_ready=%b, want 00/0/1", HTRANS, busy, in_ready);
        end
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        repeat (40) begin @(posedge HCLK); #1; end
        checks++;
        if (wa_q.size() != 0 || wd_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midop_nowrite: %0d addr %0d data busy=%b, want 0/0/0", wa_q.size(), wd_q.size(), busy);
        end
        test_value("after_reset42", 32'd42, 1'b0, 8'h00, 35, 32'h0000_0402, 32'h0);
    endtask

    task automatic test_back_to_back();
        int e;
        wa_q.delete(); wd_q.delete();
        in_value = 32'h0123_4567; in_hex = 1'b1; in_dp = 8'h00; in_valid = 1'b1;
        @(posedge HCLK); #1;            // first accepted
        in_value = 32'h89AB_CDEF;       // valid stays high while busy
        repeat (3) begin @(posedge HCLK); #1; end
        checks++;
        if (done !== 1'b1 || in_ready !== 1'b1 || HTRANS !== 2'b00) begin
            errors++;
            $display("FAIL b2b_first_done: done=%b in_ready=%b HTRANS=%b, want 1/1/00", done, in_ready, HTRANS);
        end
        @(posedge HCLK); #1;            // second accepted
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || HTRANS !== 2'b10 || HADDR !== 16'h0000) begin
            errors++;
            $display("FAIL b2b_second_accept: busy=%b HTRANS=%b HADDR=%h, want 1/10/0000", busy, HTRANS, HADDR);
        end
        e = 0;
        while (!done && e < 200) begin @(posedge HCLK); #1; e++; end
        checks++;
        if (e !== 3) begin
            errors++;
            $display("FAIL b2b_latency: %0d edges, want 3", e);
        end
        checks++;
        if (wd_q.size() != 4 || wa_q.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: %0d addr %0d data, want 4/4", wa_q.size(), wd_q.size());
        end else if (wd_q[0] !== 32'h0405_0607 || wd_q[1] !== 32'h0001_0203 ||
                     wd_q[2] !== 32'h0C0D_0E0F || wd_q[3] !== 32'h0809_0A0B ||
                     wa_q[0] !== 16'h0000 || wa_q[1] !== 16'h0004 ||
                     wa_q[2] !== 16'h0000 || wa_q[3] !== 16'h0004) begin
            errors++;
            $display("FAIL b2b_writes: %h:%h %h:%h %h:%h %h:%h, want 0000:04050607 0004:00010203 0000:0c0d0e0f 0004:08090a0b",
                     wa_q[0], wd_q[0], wa_q[1], wd_q[1], wa_q[2], wd_q[2], wa_q[3], wd_q[3]);
        end
    endtask

    initial begin
        #12;
        test_reset();
        #3 HRESETn = 1'b1;
        @(posedge HCLK); #1;
        test_value("dec12345678", 32'd12345678, 1'b0, 8'h00, 35, 32'h0506_0708, 32'h0102_0304);
        test_value("hexdeadbeef", 32'hDEAD_BEEF, 1'b1, 8'h81, 3, 32'h0B0E_0E1F, 32'h1D0E_0A0D);
        test_value("overflow", 32'd100000000, 1'b0, 8'h00, 3, 32'h0F0F_0F0F, 32'h0F0F_0F0F);
        test_value("dec_max", 32'd99999999, 1'b0, 8'h00, 35, 32'h0909_0909, 32'h0909_0909);
        test_value("dec_zero", 32'd0, 1'b0, 8'h00, 35, 32'h0, 32'h0);
        test_stall_err();
        test_reset_midop();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
